// File: rtl/bcd_serial_adder_pkg.sv
// bcd_serial_adder_pkg
// Shared definitions for the serial packed-BCD adder and its digit stage:
// the controller state encoding and the decimal constants used by the
// single-digit add/correct rule.
package bcd_serial_adder_pkg;

  // Controller states: wait for start, add one digit per cycle, pulse done.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits per packed BCD digit.
  localparam int DIGIT_W = 4;

  // Largest legal decimal digit, and the amount added to a binary digit
  // sum above it so that the low nibble wraps to the decimal result.
  localparam logic [4:0] BCD_MAX  = 5'd9;
  localparam logic [4:0] BCD_CORR = 5'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add
// Combinational single-digit BCD adder stage.
// Ports:
//   a_d, b_d : operand digits (4 bits each)
//   ci       : decimal carry in
//   s_d      : corrected sum digit
//   co       : decimal carry out
//   bad      : either operand digit is above 9
module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       ci,
  output logic [3:0] s_d,
  output logic       co,
  output logic       bad
);

  logic [4:0] raw;

  // Five-bit binary sum (at most 15+15+1 = 31). Above 9 the +6 correction
  // is applied to the low nibble only, which is all the digit keeps; this
  // also gives a defined (non-decimal) result for illegal operand digits.
  always_comb begin
    raw = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, ci};
    if (raw > BCD_MAX) begin
      s_d = raw[3:0] + BCD_CORR[3:0];
      co  = 1'b1;
    end else begin
      s_d = raw[3:0];
      co  = 1'b0;
    end
    bad = ({1'b0, a_d} > BCD_MAX) || ({1'b0, b_d} > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder
// Multi-digit packed-BCD adder that feeds one bcd_digit_add stage per
// cycle, least-significant digit first, chaining the decimal carry.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : request, accepted only while idle
//   a, b  : packed BCD operands, digit 0 in bits [3:0]
//   cin   : decimal carry into digit 0
//   busy  : high from the cycle after acceptance through the done cycle
//   done  : one-cycle pulse when sum/cout/err are valid
//   sum   : packed BCD result (registered, held until next acceptance)
//   cout  : decimal carry out of the top digit
//   err   : some operand digit was above 9
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W  = DIGIT_W * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry;
  logic [IW-1:0] idx;
  logic          accept;
  logic          last;
  logic [3:0]    s_d;
  logic          co;
  logic          bad;

  assign accept = (state == IDLE) && start;
  assign last   = (idx == LAST_IDX);

  // The captured operands are shifted right one digit per ADD cycle, so
  // the current digit is always in the low nibble.
  bcd_digit_add u_digit (
    .a_d (a_q[3:0]),
    .b_d (b_q[3:0]),
    .ci  (carry),
    .s_d (s_d),
    .co  (co),
    .bad (bad)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath: capture on acceptance, then one digit per ADD cycle. cout is
  // deliberately left alone at acceptance and only updated on the last digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      carry <= cin;
      idx   <= '0;
      sum   <= '0;
      err   <= 1'b0;
    end else if (state == ADD) begin
      a_q   <= a_q >> DIGIT_W;
      b_q   <= b_q >> DIGIT_W;
      carry <= co;
      err   <= err | bad;
      for (int i = 0; i < DIGITS; i++) begin
        if (idx == IW'(i)) begin
          sum[DIGIT_W*i +: DIGIT_W] <= s_d;
        end
      end
      if (last) begin
        cout <= co;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder
// Randomised self-checking bench for bcd_serial_adder, exercising a
// four-digit and a one-digit build side by side against a digit-by-digit
// decimal reference model.
module tb_bcd_serial_adder;

  localparam int D4 = 4;
  localparam int D1 = 1;

  logic        clk;
  logic        rst;
  logic        start4, start1;
  logic [15:0] a4, b4;
  logic [3:0]  a1, b1;
  logic        cin4, cin1;
  logic        busy4, done4, cout4, err4;
  logic        busy1, done1, cout1, err1;
  logic [15:0] sum4;
  logic [3:0]  sum1;

  int numCompared   = 0;
  int numMismatched = 0;

  bcd_serial_adder #(.DIGITS(D4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4),
    .err   (err4)
  );

  bcd_serial_adder #(.DIGITS(D1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1),
    .err   (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: walk the digits with plain integer arithmetic.
  // Returns {err, cout, sum}.
  function automatic logic [17:0] refAdd(input logic [15:0] av, input logic [15:0] bv,
                                         input logic ci, input int nd);
    int carry, da, db, t;
    logic [15:0] s;
    logic e;
    carry = ci ? 1 : 0;
    s = '0;
    e = 1'b0;
    for (int k = 0; k < nd; k++) begin
      da = int'((av >> (4 * k)) & 16'hF);
      db = int'((bv >> (4 * k)) & 16'hF);
      if (da > 9 || db > 9) e = 1'b1;
      t = da + db + carry;
      if (t > 9) begin
        t = (t + 6) % 16;
        carry = 1;
      end else begin
        carry = 0;
      end
      s = s | (16'(t) << (4 * k));
    end
    return {e, (carry != 0), s};
  endfunction

  // Mostly legal digits, with an occasional illegal one (10..15).
  function automatic logic [15:0] randDigits(input int nd);
    logic [15:0] v;
    int d;
    v = '0;
    for (int k = 0; k < nd; k++) begin
      if ($urandom_range(0, 99) < 10) d = int'($urandom_range(10, 15));
      else d = int'($urandom_range(0, 9));
      v = v | (16'(d) << (4 * k));
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full operation on the selected build: accept, check the cleared
  // state, wait (bounded) for done, check latency, result and hold.
  task automatic applyStimulus(input int sel, input logic [15:0] av, input logic [15:0] bv,
                               input logic ci);
    int nd, cyc;
    logic [17:0] expv;
    logic seen, prevCout;
    logic [15:0] obsSum;
    nd = (sel == 1) ? D1 : D4;
    expv = refAdd(av, bv, ci, nd);
    prevCout = (sel == 1) ? cout1 : cout4;
    @(negedge clk);
    if (sel == 1) begin
      start1 = 1'b1; a1 = av[3:0]; b1 = bv[3:0]; cin1 = ci;
    end else begin
      start4 = 1'b1; a4 = av; b4 = bv; cin4 = ci;
    end
    @(negedge clk);
    cyc = 1;
    if (sel == 1) begin
      start1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom); cin1 = ~ci;
    end else begin
      start4 = 1'b0; a4 = 16'($urandom); b4 = 16'($urandom); cin4 = ~ci;
    end
    obsSum = (sel == 1) ? {12'h0, sum1} : sum4;
    checkOutput("busyAfterAccept", (sel == 1) ? busy1 : busy4, 1);
    checkOutput("sumClearedAtAccept", obsSum, 0);
    checkOutput("errClearedAtAccept", (sel == 1) ? err1 : err4, 0);
    checkOutput("coutHeldAtAccept", (sel == 1) ? cout1 : cout4, prevCout);
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      if ((sel == 1) ? done1 : done4) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput("doneSeen", seen, 1);
    checkOutput("doneLatency", cyc, nd + 1);
    obsSum = (sel == 1) ? {12'h0, sum1} : sum4;
    checkOutput("sum", obsSum, expv[15:0]);
    checkOutput("cout", (sel == 1) ? cout1 : cout4, expv[16]);
    checkOutput("err", (sel == 1) ? err1 : err4, expv[17]);
    checkOutput("busyAtDone", (sel == 1) ? busy1 : busy4, 1);
    @(negedge clk);
    obsSum = (sel == 1) ? {12'h0, sum1} : sum4;
    checkOutput("donePulseEnds", (sel == 1) ? done1 : done4, 0);
    checkOutput("busyAfterDone", (sel == 1) ? busy1 : busy4, 0);
    checkOutput("sumHeld", obsSum, expv[15:0]);
    checkOutput("coutHeld", (sel == 1) ? cout1 : cout4, expv[16]);
  endtask

  initial begin
    logic [15:0] opsA [0:17];
    logic [15:0] opsB [0:17];
    logic        opsC [0:17];
    logic [17:0] expv;
    int numDone;
    int period;

    rst = 1'b1;
    start4 = 1'b0; start1 = 1'b0;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("resetBusy4", busy4, 0);
    checkOutput("resetDone4", done4, 0);
    checkOutput("resetSum4", sum4, 0);
    checkOutput("resetCout4", cout4, 0);
    checkOutput("resetErr4", err4, 0);
    checkOutput("resetBusy1", busy1, 0);
    checkOutput("resetSum1", sum1, 0);
    rst = 1'b0;

    // Directed cases.
    applyStimulus(4, 16'h1234, 16'h5678, 1'b0);
    applyStimulus(4, 16'h9999, 16'h0001, 1'b0);
    applyStimulus(4, 16'h0000, 16'h0000, 1'b1);
    applyStimulus(4, 16'h00A0, 16'h0005, 1'b0);
    applyStimulus(1, 16'h0008, 16'h0009, 1'b1);

    // Randomised operations on both builds.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4, randDigits(D4), randDigits(D4), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, randDigits(D1), randDigits(D1), 1'($urandom_range(0, 1)));
    end

    // start held high with operands changing every cycle: a new operation
    // is taken every DIGITS+2 cycles, each using its own captured operands.
    period = D4 + 2;
    numDone = 0;
    for (int j = 0; j <= 3 * period; j++) begin
      @(negedge clk);
      if (j >= 1) begin
        checkOutput("streamDone", done4, (j % period) == (D4 + 1));
        if (done4) begin
          numDone++;
          expv = refAdd(opsA[j - D4 - 1], opsB[j - D4 - 1], opsC[j - D4 - 1], D4);
          checkOutput("streamSum", sum4, expv[15:0]);
          checkOutput("streamCout", cout4, expv[16]);
          checkOutput("streamErr", err4, expv[17]);
        end
      end
      if (j < 3 * period) begin
        opsA[j] = randDigits(D4);
        opsB[j] = randDigits(D4);
        opsC[j] = 1'($urandom_range(0, 1));
        start4 = 1'b1; a4 = opsA[j]; b4 = opsB[j]; cin4 = opsC[j];
      end else begin
        start4 = 1'b0;
      end
    end
    checkOutput("streamDoneCount", numDone, 3);
    @(negedge clk);

    // Reset in the middle of an operation abandons it.
    applyStimulus(4, 16'h9A99, 16'h0001, 1'b0);
    @(negedge clk);
    start4 = 1'b1; a4 = 16'h11A1; b4 = 16'h1111; cin4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midOpSum", sum4, 16'h0012);
    checkOutput("midOpErr", err4, 1);
    checkOutput("midOpCout", cout4, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midResetBusy", busy4, 0);
    checkOutput("midResetDone", done4, 0);
    checkOutput("midResetSum", sum4, 0);
    checkOutput("midResetCout", cout4, 0);
    checkOutput("midResetErr", err4, 0);
    numDone = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (done4) numDone++;
    end
    checkOutput("noDoneAfterReset", numDone, 0);
    applyStimulus(4, 16'h0005, 16'h0005, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
